// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: one shared run-of-ones detector, time-shared round-robin
//   across NCH serial bit-stream channels. Each channel keeps its own run count.
// Latency: a hit is visible on hit_valid/hit_ch the cycle after the consuming grant.
// Backpressure: a pending hit with hit_ready low holds the output and blocks all grants.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_bit      per-channel offered bit
//   req_ready              per-channel one-hot grant (combinational)
//   clr                    per-channel synchronous run-count clear
//   hit_valid/hit_ch       pending hit event and its channel
//   hit_ready              consumer accept for the pending hit
//   hit_count              16-bit wrapping count of hits produced since reset
module seq_detect_scheduler #(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         req_valid,
  input  logic [NCH-1:0]         req_bit,
  output logic [NCH-1:0]         req_ready,
  input  logic [NCH-1:0]         clr,
  output logic                   hit_valid,
  output logic [$clog2(NCH)-1:0] hit_ch,
  input  logic                   hit_ready,
  output logic [15:0]            hit_count
);

  localparam int PW = $clog2(NCH);
  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RUN_LEN);
  localparam logic [CW-1:0] CNT_PRE = CW'(RUN_LEN - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NCH - 1);

  // Saved per-channel contexts and shared state
  logic [CW-1:0] r_cnt [NCH];
  logic [PW-1:0] r_ptr;
  logic          r_hit_valid;
  logic [PW-1:0] r_hit_ch;
  logic [15:0]   r_hit_count;

  // Arbitration and engine datapath
  logic          w_slot_free;
  logic          w_req_found;
  logic [PW-1:0] w_req_idx;
  logic          w_grant;
  logic          w_bit;
  logic          w_clr;
  logic [CW-1:0] w_cnt_cur;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_hit;
  logic [PW-1:0] w_ptr_nxt;

  // The output slot can take a new hit if empty or being drained this cycle.
  assign w_slot_free = !r_hit_valid || hit_ready;

  // Round-robin search starting at r_ptr, wrapping modulo NCH.
  always_comb begin
    w_req_found = 1'b0;
    w_req_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_req_found && req_valid[(int'(r_ptr) + k) % NCH]) begin
        w_req_found = 1'b1;
        w_req_idx   = PW'((int'(r_ptr) + k) % NCH);
      end
    end
  end

  // Gating with rst_n keeps req_ready low throughout reset.
  assign w_grant = rst_n && w_req_found && w_slot_free;

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_req_idx] = 1'b1;
    end
  end

  // Shared engine: operates on the granted channel's saved context.
  assign w_bit     = req_bit[w_req_idx];
  assign w_clr     = clr[w_req_idx];
  assign w_cnt_cur = r_cnt[w_req_idx];

  // Clear beats the offered bit; a 1 saturates at RUN_LEN.
  always_comb begin
    w_cnt_nxt = '0;
    if (!w_clr && w_bit) begin
      if (w_cnt_cur == CNT_MAX) begin
        w_cnt_nxt = CNT_MAX;
      end else begin
        w_cnt_nxt = w_cnt_cur + CW'(1);
      end
    end
  end

  // Only the transition RUN_LEN-1 -> RUN_LEN is a hit; saturated 1s are silent.
  assign w_hit = w_grant && w_bit && !w_clr && (w_cnt_cur == CNT_PRE);

  assign w_ptr_nxt = (w_req_idx == IDX_LAST) ? '0 : (w_req_idx + PW'(1));

  // Per-channel contexts: granted channel takes the engine result, others
  // only react to their own clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_grant && (w_req_idx == PW'(i))) begin
          r_cnt[i] <= w_cnt_nxt;
        end else if (clr[i]) begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Output slot: a newly loaded hit wins over the accept of the old one,
  // which sustains one hit per cycle when hit_ready stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_valid <= 1'b0;
      r_hit_ch    <= '0;
      r_hit_count <= '0;
    end else begin
      if (w_hit) begin
        r_hit_valid <= 1'b1;
        r_hit_ch    <= w_req_idx;
        r_hit_count <= r_hit_count + 16'd1;
      end else if (hit_ready) begin
        r_hit_valid <= 1'b0;
      end
    end
  end

  assign hit_valid = r_hit_valid;
  assign hit_ch    = r_hit_ch;
  assign hit_count = r_hit_count;

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 Parameter NCH, default 4, number of serial bit-stream requesters (2..16).
REQ-002 Parameter RUN_LEN, default 3, consecutive-1 run length that produces a hit (1..15).
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NCH  per-channel: a bit is offered.
REQ-006 req_bit  input  NCH  per-channel offered bit value.
REQ-007 req_ready  output  NCH  per-channel grant; the offered bit is consumed in a cycle with req_valid[i] && req_ready[i].
REQ-008 clr  input  NCH  per-channel synchronous context clear.
REQ-009 hit_valid  output  1  hit event pending in the output register.
REQ-010 hit_ch  output  $clog2(NCH)  channel index of the pending hit.
REQ-011 hit_ready  input  1  consumer accepts the hit when hit_valid && hit_ready.
REQ-012 hit_count  output  16  total hits produced since reset.

Function
REQ-013 The block SHALL time-share one run-detect engine among NCH channels, holding a saved run count cnt[i] of width $clog2(RUN_LEN+1) per channel.
REQ-014 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be combinational from req_valid, the round-robin pointer and the output-slot state.
REQ-015 Arbitration: round-robin, searching from ptr upward with wrap; the first i with req_valid[i] is granted.
REQ-016 ptr SHALL update to (granted index + 1) mod NCH on every grant and hold otherwise.
REQ-017 A grant SHALL be issued only when the output slot is free or draining: !hit_valid || hit_ready.
REQ-018 Consumed bit = 1: cnt[i] <= min(cnt[i]+1, RUN_LEN); consumed bit = 0: cnt[i] <= 0.
REQ-019 A hit SHALL be generated exactly when a consumed 1 moves cnt[i] from RUN_LEN-1 to RUN_LEN; further 1s while saturated SHALL produce no hit until a 0 restarts the run.
REQ-020 Hit latency: hit_valid=1 and hit_ch=i on the cycle after the consuming cycle.
REQ-021 hit_valid SHALL clear on accept unless a new hit is loaded in the same cycle; with back-to-back hits and hit_ready held high, one hit per cycle SHALL be sustained.
REQ-022 hit_valid && !hit_ready SHALL hold hit_valid and hit_ch stable and SHALL deassert all req_ready.
REQ-023 hit_count SHALL increment by 1 for each hit loaded, wrapping 0xFFFF -> 0x0000.
REQ-024 clr[i] SHALL force cnt[i] <= 0 next cycle.
REQ-025 If clr[i] coincides with a grant to i, clr SHALL win: the bit is consumed, cnt[i] becomes 0 and no hit is produced.
REQ-026 clr SHALL NOT affect arbitration, ptr, the output register or hit_count.
REQ-027 Channels not granted in a cycle SHALL keep cnt unchanged.
REQ-028 With RUN_LEN=1, every 1 consumed while cnt[i]=0 SHALL produce a hit.

Reset
REQ-029 While rst_n=0: all cnt = 0, ptr = 0, hit_valid = 0, hit_ch = 0, hit_count = 0, req_ready = 0.
REQ-030 Reset assertion mid-operation SHALL discard a pending unaccepted hit and all saved contexts immediately.
REQ-031 The first grant after deassertion SHALL search from channel 0.

Verification
REQ-032 Single channel: ch0 offers 1,1,1,1,0,1,1,1 with hit_ready=1 -> exactly two hits (after the 3rd and 8th bits), hit_ch=0, hit_count=2.
REQ-033 Fairness: all four req_valid high for 8 cycles -> grants 0,1,2,3,0,1,2,3; each channel's cnt advances independently.
REQ-034 Interleaved contexts: ch1 and ch2 each offer 1,1,1 while both request every cycle -> hits on ch1 then ch2 on consecutive cycles; no cross-channel corruption.
REQ-035 Backpressure: hit pending with hit_ready=0 for 5 cycles -> req_ready all 0 and hit_ch stable; hit_ready=1 -> hit accepted and grants resume from ptr.
REQ-036 clr collision: ch3 at cnt=2 is granted bit 1 with clr[3]=1 -> no hit, cnt[3]=0; the next 1,1,1 on ch3 -> one hit.
REQ-037 Async reset asserted with a hit pending and hit_count=7 -> hit_valid=0 and hit_count=0 immediately, without a clock edge.
